// File: rtl/stim_pkg.sv
// Shared definitions for the stimulation controller: state encoding and the
// default timing values shared with the top-level datapath wrapper.
package stim_pkg;

   // FSM state encoding, kept as plain vectors for compatibility with older tooling
   typedef logic [2:0] stim_state_t;

   localparam stim_state_t ST_IDLE    = 3'd0;
   localparam stim_state_t ST_PHASE_A = 3'd1;
   localparam stim_state_t ST_PHASE_B = 3'd2;
   localparam stim_state_t ST_GAP     = 3'd3;
   localparam stim_state_t ST_REFRACT = 3'd4;

   // Default timing, all in clk cycles
   localparam int unsigned STIM_CONFIRM_COUNT  = 4;
   localparam int unsigned STIM_PHASE_CYCLES   = 4;
   localparam int unsigned STIM_GAP_CYCLES     = 16;
   localparam int unsigned STIM_PULSE_COUNT    = 8;
   localparam int unsigned STIM_REFRACT_CYCLES = 256;
   localparam int unsigned STIM_CNT_WIDTH      = 16;

endpackage

// File: rtl/stim_timer.sv
// Loadable down-counter used to time the pulse phases, the inter-pulse gap
// and the refractory lockout. A load always wins over hold so that a train
// kill can arm the lockout even while the controller is frozen.
module stim_timer
   import stim_pkg::*;
#(
   parameter int unsigned CNT_WIDTH = STIM_CNT_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load,
   input  logic [CNT_WIDTH-1:0] value,
   input  logic                 hold,
   output logic                 done
);

   logic [CNT_WIDTH-1:0] count_q;
   logic [CNT_WIDTH-1:0] count_d;

   // Next count: load, otherwise decrement toward zero unless frozen
   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = value;
      end else if (!hold && (count_q != '0)) begin
         count_d = count_q - 1'b1;
      end
   end

   // Count register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // Expiry is only reported on cycles that are allowed to advance
   assign done = (count_q == '0) && !hold;

endmodule

// File: rtl/stim_controller.sv
// Stimulation controller: turns a run of consecutive seizure detections into
// a bounded pulse train followed by a refractory lockout.
// Build option: define STIM_BIPHASIC_EN for biphasic pulses (A then B phase);
// without it the pulses are monophasic and stim_b is tied low.
module stim_controller
   import stim_pkg::*;
#(
   parameter int unsigned CONFIRM_COUNT  = STIM_CONFIRM_COUNT,
   parameter int unsigned PHASE_CYCLES   = STIM_PHASE_CYCLES,
   parameter int unsigned GAP_CYCLES     = STIM_GAP_CYCLES,
   parameter int unsigned PULSE_COUNT    = STIM_PULSE_COUNT,
   parameter int unsigned REFRACT_CYCLES = STIM_REFRACT_CYCLES,
   parameter int unsigned CNT_WIDTH      = STIM_CNT_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 detect,
   input  logic                 abort,
   output logic                 stim_a,
   output logic                 stim_b,
   output logic                 busy,
   output logic                 refract,
   output logic [CNT_WIDTH-1:0] train_count
);

   // Timer load values are one less than the duration: the state is entered
   // on the loading edge and left on the edge that sees the timer at zero.
   localparam logic [CNT_WIDTH-1:0] CONFIRM_LAST = CNT_WIDTH'(CONFIRM_COUNT - 1);
   localparam logic [CNT_WIDTH-1:0] PHASE_LOAD   = CNT_WIDTH'(PHASE_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] GAP_LOAD     = CNT_WIDTH'(GAP_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] REFRACT_LOAD = CNT_WIDTH'(REFRACT_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] PULSE_LAST   = CNT_WIDTH'(PULSE_COUNT - 1);

   stim_state_t          state_q;
   stim_state_t          state_d;
   logic [CNT_WIDTH-1:0] confirm_q;
   logic [CNT_WIDTH-1:0] confirm_d;
   logic [CNT_WIDTH-1:0] pulse_idx_q;
   logic [CNT_WIDTH-1:0] pulse_idx_d;
   logic [CNT_WIDTH-1:0] train_cnt_q;
   logic [CNT_WIDTH-1:0] train_cnt_d;

   logic                 tmr_load;
   logic [CNT_WIDTH-1:0] tmr_value;
   logic                 tmr_done;

   logic                 pulse_end;
   logic                 kill;

   logic                 stim_a_q;
   logic                 busy_q;
   logic                 refract_q;

   // Single timer shared by phase, gap and refractory intervals
   stim_timer #(
      .CNT_WIDTH (CNT_WIDTH)
   ) u_timer (
      .clk   (clk),
      .rst   (rst),
      .load  (tmr_load),
      .value (tmr_value),
      .hold  (!en),
      .done  (tmr_done)
   );

   // Next-state, confirm counter, pulse index and train counter logic
   always_comb begin
      state_d     = state_q;
      confirm_d   = confirm_q;
      pulse_idx_d = pulse_idx_q;
      train_cnt_d = train_cnt_q;
      tmr_load    = 1'b0;
      tmr_value   = '0;
      pulse_end   = 1'b0;
      kill        = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // abort beats a confirming detect on the same cycle
            if (abort) begin
               confirm_d = '0;
            end else if (en) begin
               if (!detect) begin
                  confirm_d = '0;
               end else if (confirm_q == CONFIRM_LAST) begin
                  state_d     = ST_PHASE_A;
                  confirm_d   = '0;
                  pulse_idx_d = '0;
                  tmr_load    = 1'b1;
                  tmr_value   = PHASE_LOAD;
               end else begin
                  confirm_d = confirm_q + 1'b1;
               end
            end
         end

         ST_PHASE_A: begin
            if (abort) begin
               kill = 1'b1;
            end else if (tmr_done) begin
`ifdef STIM_BIPHASIC_EN
               state_d   = ST_PHASE_B;
               tmr_load  = 1'b1;
               tmr_value = PHASE_LOAD;
`else
               pulse_end = 1'b1;
`endif
            end
         end

`ifdef STIM_BIPHASIC_EN
         ST_PHASE_B: begin
            if (abort) begin
               kill = 1'b1;
            end else if (tmr_done) begin
               pulse_end = 1'b1;
            end
         end
`endif

         ST_GAP: begin
            if (abort) begin
               kill = 1'b1;
            end else if (tmr_done) begin
               state_d   = ST_PHASE_A;
               tmr_load  = 1'b1;
               tmr_value = PHASE_LOAD;
            end
         end

         ST_REFRACT: begin
            // abort has no effect here; detections are ignored
            if (tmr_done) begin
               state_d   = ST_IDLE;
               confirm_d = '0;
            end
         end

         default: begin
            state_d   = ST_IDLE;
            confirm_d = '0;
         end
      endcase

      // A killed train goes straight to a full lockout without being counted
      if (kill) begin
         state_d   = ST_REFRACT;
         tmr_load  = 1'b1;
         tmr_value = REFRACT_LOAD;
      end else if (pulse_end) begin
         tmr_load = 1'b1;
         if (pulse_idx_q < PULSE_LAST) begin
            state_d     = ST_GAP;
            tmr_value   = GAP_LOAD;
            pulse_idx_d = pulse_idx_q + 1'b1;
         end else begin
            state_d     = ST_REFRACT;
            tmr_value   = REFRACT_LOAD;
            train_cnt_d = (&train_cnt_q) ? train_cnt_q : train_cnt_q + 1'b1;
         end
      end
   end

   // State and counter registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         confirm_q   <= '0;
         pulse_idx_q <= '0;
         train_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         confirm_q   <= confirm_d;
         pulse_idx_q <= pulse_idx_d;
         train_cnt_q <= train_cnt_d;
      end
   end

   // Registered Moore decodes, updated on the same edge as the state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stim_a_q  <= 1'b0;
         busy_q    <= 1'b0;
         refract_q <= 1'b0;
      end else begin
         stim_a_q  <= (state_d == ST_PHASE_A);
         busy_q    <= (state_d != ST_IDLE);
         refract_q <= (state_d == ST_REFRACT);
      end
   end

`ifdef STIM_BIPHASIC_EN
   logic stim_b_q;

   // Phase-B drive decode, only present in the biphasic build
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stim_b_q <= 1'b0;
      end else begin
         stim_b_q <= (state_d == ST_PHASE_B);
      end
   end

   assign stim_b = stim_b_q;
`else
   assign stim_b = 1'b0;
`endif

   assign stim_a      = stim_a_q;
   assign busy        = busy_q;
   assign refract     = refract_q;
   assign train_count = train_cnt_q;

endmodule

// File: tb/tb_stim_controller.sv
// Scoreboard bench for stim_controller: every driven cycle pushes the
// expected {stim_a, stim_b, busy, refract, train_count}; a monitor pops and
// compares one entry after each rising edge.
module tb_stim_controller;

   localparam int CONF  = 4;
   localparam int PH    = 4;
   localparam int GAP   = 16;
   localparam int NPULS = 8;
   localparam int REF   = 256;
   localparam int W     = 16;

`ifdef STIM_BIPHASIC_EN
   localparam bit BIPH = 1'b1;
`else
   localparam bit BIPH = 1'b0;
`endif

   // expected flag patterns {stim_a, stim_b, busy, refract}
   localparam logic [3:0] E_IDLE = 4'b0000;
   localparam logic [3:0] E_A    = 4'b1010;
   localparam logic [3:0] E_B    = 4'b0110;
   localparam logic [3:0] E_GAP  = 4'b0010;
   localparam logic [3:0] E_REF  = 4'b0011;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         en = 1'b0;
   logic         detect = 1'b0;
   logic         abort = 1'b0;
   logic         stim_a, stim_b, busy, refract;
   logic [W-1:0] train_count;

   int n_cmp = 0;
   int n_err = 0;
   int cyc_no = 0;
   logic [W-1:0] exp_tc = '0;
   logic [W+3:0] exp_q[$];

   stim_controller #(
      .CONFIRM_COUNT  (CONF),
      .PHASE_CYCLES   (PH),
      .GAP_CYCLES     (GAP),
      .PULSE_COUNT    (NPULS),
      .REFRACT_CYCLES (REF),
      .CNT_WIDTH      (W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .detect      (detect),
      .abort       (abort),
      .stim_a      (stim_a),
      .stim_b      (stim_b),
      .busy        (busy),
      .refract     (refract),
      .train_count (train_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // drive one cycle of inputs and record what the outputs must be after the edge
   task automatic cyc(input logic e, input logic d, input logic a, input logic [3:0] flags);
      @(negedge clk);
      en     = e;
      detect = d;
      abort  = a;
      exp_q.push_back({flags, exp_tc});
   endtask

   function automatic logic rnd_bit();
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic idle(input int n, input logic d);
      for (int i = 0; i < n; i++) cyc(1'b1, d, 1'b0, E_IDLE);
   endtask

   // refractory lockout; abort pulsed mid-way must not restart it
   task automatic refract_run(input int n);
      for (int i = 0; i < n; i++) cyc(1'b1, rnd_bit(), (i == 10), E_REF);
   endtask

   // full or aborted train; the first cycle drives the confirming detect
   task automatic run_train(input int stall_pulse, input int abort_gap, input int abort_off);
      bit first = 1'b1;
      for (int p = 0; p < NPULS; p++) begin
         for (int k = 0; k < PH; k++) begin
            cyc(1'b1, first ? 1'b1 : rnd_bit(), 1'b0, E_A);
            first = 1'b0;
            if (p == stall_pulse && k == 1) begin
               for (int s = 0; s < 10; s++) cyc(1'b0, rnd_bit(), 1'b0, E_A);
            end
         end
         if (BIPH) begin
            for (int k = 0; k < PH; k++) cyc(1'b1, rnd_bit(), 1'b0, E_B);
         end
         if (p < NPULS - 1) begin
            for (int g = 0; g < GAP; g++) begin
               if (p == abort_gap && g == abort_off) begin
                  // abort while frozen still takes effect at this edge
                  cyc(1'b0, rnd_bit(), 1'b1, E_REF);
                  refract_run(REF - 1);
                  return;
               end
               cyc(1'b1, rnd_bit(), 1'b0, E_GAP);
            end
         end
      end
      exp_tc = exp_tc + 1'b1;
      refract_run(REF);
   endtask

   // scoreboard monitor
   always begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
         logic [W+3:0] e;
         e = exp_q.pop_front();
         check($sformatf("outs@%0d", cyc_no),
               32'({stim_a, stim_b, busy, refract, train_count}), 32'(e));
         cyc_no++;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_stim_a", 32'(stim_a), 32'd0);
      check("rst_stim_b", 32'(stim_b), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_refract", 32'(refract), 32'd0);
      check("rst_train_count", 32'(train_count), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      idle(3, 1'b0);
      $display("[tb] reset state checked");

      // confirm and full train
      idle(CONF - 1, 1'b1);
      run_train(-1, -1, 0);
      idle(3, 1'b0);
      $display("[tb] confirm + full train done, train_count=%0d", exp_tc);

      // broken confirm 1,1,1,0,1,1,1,1 with a 10-cycle freeze in PHASE_A
      idle(3, 1'b1);
      idle(1, 1'b0);
      idle(3, 1'b1);
      run_train(0, -1, 0);
      idle(3, 1'b0);
      $display("[tb] broken confirm + stalled phase done, train_count=%0d", exp_tc);

      // freeze mid-confirm, then abort in the third gap
      idle(2, 1'b1);
      for (int i = 0; i < 10; i++) cyc(1'b0, rnd_bit(), 1'b0, E_IDLE);
      idle(1, 1'b1);
      run_train(-1, 2, 5);
      idle(3, 1'b0);
      $display("[tb] frozen confirm + gap abort done, train_count=%0d", exp_tc);

      // abort together with the confirming detect: no fire, counter cleared
      idle(3, 1'b1);
      cyc(1'b1, 1'b1, 1'b1, E_IDLE);
      idle(3, 1'b1);
      idle(2, 1'b0);
      $display("[tb] abort on confirming detect done");

      // asynchronous reset in the middle of a pulse
      idle(CONF - 1, 1'b1);
      cyc(1'b1, 1'b1, 1'b0, E_A);
      if (BIPH) begin
         for (int k = 1; k < PH; k++) cyc(1'b1, 1'b0, 1'b0, E_A);
         for (int k = 0; k < 2; k++) cyc(1'b1, 1'b0, 1'b0, E_B);
      end else begin
         cyc(1'b1, 1'b0, 1'b0, E_A);
      end
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      exp_tc = '0;
      check("arst_stim_a", 32'(stim_a), 32'd0);
      check("arst_stim_b", 32'(stim_b), 32'd0);
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_refract", 32'(refract), 32'd0);
      check("arst_train_count", 32'(train_count), 32'(exp_tc));
      @(negedge clk);
      rst = 1'b0;
      idle(4, 1'b0);
      $display("[tb] async reset mid-pulse done");

      @(posedge clk);
      #3;
      check("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/stim_controller.md
# stim_controller

Converts the single-bit seizure-detect output of `datapath` (`stimulation`) into a bounded, timed stimulation pulse train for the electrode driver. It sits directly downstream of `datapath` and requires a run of consecutive detections before firing. It then emits a fixed number of pulses and enforces a refractory lockout before it can re-arm. All timing is in `clk` cycles, one detect sample per enabled cycle.

## Interface
- `CONFIRM_COUNT`, 4: consecutive enabled cycles with `detect`=1 needed to fire; must be ≥1.
- `PHASE_CYCLES`, 4: length of each pulse phase; must be ≥1.
- `GAP_CYCLES`, 16: inter-pulse gap; must be ≥1.
- `PULSE_COUNT`, 8: pulses per train; must be ≥1.
- `REFRACT_CYCLES`, 256: lockout after a train; must be ≥1.
- `CNT_WIDTH`, 16: width of internal timers and of `train_count`.

Ports:
- `clk`  in  1: clock.
- `rst`  in  1: asynchronous, active-high reset.
- `en`  in  1: advance enable; pairs with the `datapath` `en`.
- `detect`  in  1: connects to `datapath.stimulation`.
- `abort`  in  1: synchronous train kill.
- `stim_a`  out  1: phase-A (cathodic) drive.
- `stim_b`  out  1: phase-B (anodic) drive.
- `busy`  out  1: high in any state other than IDLE.
- `refract`  out  1: high in REFRACT.
- `train_count`  out  CNT_WIDTH: completed trains, saturating at all-ones.

## Operation
- FSM states: IDLE, PHASE_A, PHASE_B, GAP, REFRACT. All outputs are registered Moore decodes of the state.
- IDLE:
  - `en`&`detect` increments the confirm counter.
  - `en`&!`detect` clears the counter.
  - When the increment reaches `CONFIRM_COUNT`, the FSM goes to PHASE_A, the counter clears and the pulse index is set to 0.
- PHASE_A: lasts `PHASE_CYCLES` enabled cycles, then goes to PHASE_B.
- PHASE_B: lasts `PHASE_CYCLES` enabled cycles. On exit:
  - If the pulse index is less than `PULSE_COUNT`−1, go to GAP and increment the index.
  - Otherwise go to REFRACT and increment `train_count` (saturating).
- GAP: lasts `GAP_CYCLES`, then goes to PHASE_A.
- REFRACT: lasts `REFRACT_CYCLES`, then goes to IDLE with the confirm counter at 0.
- `detect` is ignored outside IDLE. Detections during REFRACT do not count toward the next confirm.
- `en`=0 freezes the state, all timers and the confirm counter (held, not cleared). Outputs hold their values.
- `abort`=1, regardless of `en`:
  - In PHASE_A, PHASE_B or GAP: go to REFRACT with the full `REFRACT_CYCLES` loaded. `train_count` is not incremented.
  - In IDLE: clear the confirm counter.
  - In REFRACT: no effect.
- `stim_a` and `stim_b` are never high together.

## Timing
- Reset values: state IDLE, all outputs 0, `train_count`=0, all counters 0.
- Reset mid-train: `stim_a` and `stim_b` drop asynchronously on `rst` assertion.
- Fire latency: `stim_a` rises at the same `clk` edge that samples the `CONFIRM_COUNT`-th consecutive `detect`=1.
- Train length: PULSE_COUNT·2·PHASE_CYCLES + (PULSE_COUNT−1)·GAP_CYCLES cycles. With defaults this is 64 + 112 = 176 cycles.
- After a train, `busy` stays high for a further `REFRACT_CYCLES` cycles.
- `abort` effect: outputs go low at the edge that samples `abort`.
- Simultaneous `abort` and the confirming `detect` in IDLE: `abort` wins; the FSM stays in IDLE with the counter at 0.
- `train_count` at saturation holds all-ones.

## Configuration
- `STIM_BIPHASIC_EN` defined: behaviour exactly as above.
- `STIM_BIPHASIC_EN` undefined (monophasic):
  - PHASE_B is not built; `stim_b` is tied to 0.
  - PHASE_A exits directly with the PHASE_B exit rules.
  - Train length becomes PULSE_COUNT·PHASE_CYCLES + (PULSE_COUNT−1)·GAP_CYCLES, which is 144 with defaults.

## Structure
- `stim_pkg` holds:
  - The state encoding as a typedef/enum with localparams.
  - The default parameter values shared with the top-level `datapath` wrapper.
- Sub-module `stim_timer`:
  - A CNT_WIDTH loadable down-counter with `load`, `value`, `hold` (driven from `!en`) and a `done` pulse.
  - One instance times PHASE, GAP and REFRACT.
  - The confirm counter and pulse index stay inline in `stim_controller`.

## Test plan
- Confirm and full train: `detect` high for 4 enabled cycles. Check `stim_a` rises on the 4th sampling edge, followed by 8 × (4 A, 4 B) pulses with 16-cycle gaps. Check `refract` is high for 256 cycles, `train_count`=1, then `busy`=0.
- Broken confirm: `detect` pattern 1,1,1,0,1,1,1,1. Check no fire after the first three; fire on the 8th cycle.
- Abort: assert `abort` in the 3rd GAP. Check outputs are 0 at the next edge, REFRACT runs 256 cycles and `train_count` is unchanged. Also cover `abort` coinciding with the 4th detect: no fire.
- `en` gating: `en` low for 10 cycles mid-PHASE_A and mid-confirm. Check the phase stretches by exactly 10 cycles and the confirm count is preserved.
- Async reset mid-PHASE_B: `stim_b` drops before the next edge and every output returns to its reset value.
- Monophasic build, `STIM_BIPHASIC_EN` undefined: `stim_b` is always 0 and the train lasts 144 cycles with defaults.
